// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the banked data memory.
//                FSM state type, default geometry, clog2 helper and the
//                byte-offset derivation used for address decode.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_DEPTH  = 256;
    localparam int DMEM_ADDR_W = 16;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } dmem_state_e;

    // Ceiling log2; returns at least 1 so a 1-bit index is always legal.
    function automatic int dmem_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

    // Number of low byte-address bits that select a byte inside one word.
    function automatic int dmem_off(input int data_w);
        return dmem_clog2(data_w / 8);
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_byte_lane.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_byte_lane
//  Description : One 8-bit wide, DEPTH-deep memory lane with a write port and
//                a registered read port. Read-before-write on a shared index
//                (the read sees the old contents).
//                Optional even-parity bit per byte when DMEM_PARITY_EN is
//                defined.
//  Ports       : clk, rst_n    clock / async active-low reset (read reg only)
//                we_i, widx_i, wdata_i   write strobe, word index, byte
//                re_i, ridx_i, rdata_o   read strobe, word index, read byte
//                rpar_o        stored parity of last read (DMEM_PARITY_EN)
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_byte_lane
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int IDX_W = dmem_clog2(DMEM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [7:0]       wdata_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] ridx_i,
`ifdef DMEM_PARITY_EN
    output logic             rpar_o,
`endif
    output logic [7:0]       rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Storage array is never reset; the top-level INIT sequence clears it.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[ridx_i];
        end
    end

    assign rdata_o = rdata_q;

`ifdef DMEM_PARITY_EN
    logic mem_par_q [DEPTH];
    logic rpar_q;

    // Even parity: stored bit makes the 9-bit group have an even number of 1s.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_par_q[widx_i] <= ^wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpar_q <= 1'b0;
        end else if (re_i) begin
            rpar_q <= mem_par_q[ridx_i];
        end
    end

    assign rpar_o = rpar_q;
`endif

endmodule : dmem_byte_lane
`default_nettype wire

// File: rtl/data_memory_banked.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_banked
//  Description : MEM-stage data memory built from DATA_W/8 byte lanes.
//                Power-on clear sequencer (INIT -> READY), address range and
//                alignment checking, 1-cycle registered read with a
//                read-valid strobe, per-byte write enables.
//  Config      : DMEM_PARITY_EN - store/check one even-parity bit per byte;
//                when undefined parity_err is tied low.
//  Ports       : clk, reset (async, active-low)
//                MemRead, MemWrite, ALUresult, WriteData, ByteEn   requests
//                data_result, read_valid, mem_ready, addr_err, parity_err
//  Revision    : 1.0  initial release
// ============================================================================
module data_memory_banked
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [ADDR_W-1:0]   ALUresult,
    input  logic [DATA_W-1:0]   WriteData,
    input  logic [DATA_W/8-1:0] ByteEn,
    output logic [DATA_W-1:0]   data_result,
    output logic                read_valid,
    output logic                mem_ready,
    output logic                addr_err,
    output logic                parity_err
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF   = dmem_off(DATA_W);
    localparam int IDX_W = dmem_clog2(DEPTH);
    localparam int WRD_W = ADDR_W - OFF;

    // ---------------- FSM: state register ----------------
    dmem_state_e      state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    logic init_we;
    logic ready;

    always_comb begin
        init_we = 1'b0;
        ready   = 1'b0;
        unique case (state_q)
            ST_INIT:  init_we = 1'b1;
            ST_READY: ready   = 1'b1;
            default:  init_we = 1'b0;
        endcase
    end

    // ---------------- Address decode ----------------
    logic [WRD_W-1:0] word_idx;
    logic [IDX_W-1:0] lane_idx;
    logic             misaligned;
    logic             in_range;
    logic             addr_ok;
    logic             wr_req;
    logic             rd_ok;
    logic             wr_ok;
    logic             addr_err_d;

    assign word_idx   = ALUresult[ADDR_W-1:OFF];
    assign lane_idx   = word_idx[IDX_W-1:0];
    assign misaligned = |ALUresult[OFF-1:0];
    // Widen both sides so the compare is exact whatever ADDR_W/DEPTH are.
    assign in_range   = 33'(word_idx) < 33'(DEPTH);
    assign addr_ok    = ~misaligned & in_range;

    // A write with no byte lanes enabled is not a request at all.
    assign wr_req     = MemWrite & (|ByteEn);
    assign rd_ok      = ready & MemRead & addr_ok;
    assign wr_ok      = ready & wr_req & addr_ok;
    assign addr_err_d = ready & (MemRead | wr_req) & ~addr_ok;

    logic read_valid_q;
    logic addr_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            read_valid_q <= rd_ok;
            addr_err_q   <= addr_err_d;
        end
    end

    // ---------------- Byte lanes ----------------
    logic [DATA_W-1:0] rdata;
`ifdef DMEM_PARITY_EN
    logic [LANES-1:0]  rpar;
    logic [LANES-1:0]  lane_bad;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic             lane_we;
        logic [IDX_W-1:0] lane_widx;
        logic [7:0]       lane_wdata;

        // INIT owns the write port and clears one word per cycle.
        assign lane_we    = init_we | (wr_ok & ByteEn[i]);
        assign lane_widx  = init_we ? cnt_q : lane_idx;
        assign lane_wdata = init_we ? 8'h00 : WriteData[8*i +: 8];

        dmem_byte_lane #(
            .DEPTH (DEPTH),
            .IDX_W (IDX_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (reset),
            .we_i    (lane_we),
            .widx_i  (lane_widx),
            .wdata_i (lane_wdata),
            .re_i    (rd_ok),
            .ridx_i  (lane_idx),
`ifdef DMEM_PARITY_EN
            .rpar_o  (rpar[i]),
`endif
            .rdata_o (rdata[8*i +: 8])
        );

`ifdef DMEM_PARITY_EN
        assign lane_bad[i] = (^rdata[8*i +: 8]) != rpar[i];
`endif
    end

    assign data_result = rdata;
    assign read_valid  = read_valid_q;
    assign mem_ready   = ready;
    assign addr_err    = addr_err_q;

`ifdef DMEM_PARITY_EN
    assign parity_err  = read_valid_q & (|lane_bad);
`else
    assign parity_err  = 1'b0;
`endif

endmodule : data_memory_banked
`default_nettype wire
